// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the sizing of the per-bit iteration counter.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    localparam int DIV_NBIT  = 32;
    localparam int DIV_CNT_W = $clog2(DIV_NBIT);

    // Counter width for an NBIT-step division; never narrower than one bit.
    function automatic int div_cnt_width(input int nbit);
        return (nbit <= 2) ? 1 : $clog2(nbit);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, try to
// subtract the divisor, keep the difference only when it does not borrow.
module div_step #(
    parameter int NBIT = 32
) (
    input  logic [NBIT-1:0] rem,
    input  logic [NBIT-1:0] quo,
    input  logic [NBIT-1:0] divisor,
    output logic [NBIT-1:0] rem_next,
    output logic [NBIT-1:0] quo_next
);

    logic [NBIT:0] rem_shifted;
    logic [NBIT:0] trial;

    // The extra top bit makes the trial subtraction exact, so its MSB is the borrow.
    always_comb begin
        rem_shifted = {rem, quo[NBIT-1]};
        trial       = rem_shifted - {1'b0, divisor};
        if (trial[NBIT] == 1'b0) begin
            rem_next = trial[NBIT-1:0];
            quo_next = {quo[NBIT-2:0], 1'b1};
        end else begin
            rem_next = rem_shifted[NBIT-1:0];
            quo_next = {quo[NBIT-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle signed/unsigned integer divider producing one quotient bit per
// cycle, with valid/ready handshakes on both the operand and result sides.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int NBIT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] dividend,
    input  logic [NBIT-1:0] divisor,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] quotient,
    output logic [NBIT-1:0] remainder
);

    localparam int CW = div_cnt_width(NBIT);
    localparam logic [CW-1:0]   LAST_CNT = CW'(NBIT - 1);
    localparam logic [NBIT-1:0] MIN_VAL  = {1'b1, {(NBIT-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [NBIT-1:0] rem_q, rem_d;
    logic [NBIT-1:0] quo_q, quo_d;
    logic [NBIT-1:0] div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [NBIT-1:0] quotient_q, quotient_d;
    logic [NBIT-1:0] remainder_q, remainder_d;

    logic [NBIT-1:0] step_rem;
    logic [NBIT-1:0] step_quo;
    logic [NBIT-1:0] dividend_abs;
    logic [NBIT-1:0] divisor_abs;
    logic            dividend_neg;
    logic            divisor_neg;

    div_step #(.NBIT(NBIT)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

    // Operand magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        dividend_neg = is_signed & dividend[NBIT-1];
        divisor_neg  = is_signed & divisor[NBIT-1];
        dividend_abs = dividend_neg ? (-dividend) : dividend;
        divisor_abs  = divisor_neg  ? (-divisor)  : divisor;
    end

    // Next-state logic: special cases finish immediately, everything else iterates NBIT times.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        state_d     = S_DONE;
                    end else if (is_signed && (dividend == MIN_VAL) && (divisor == '1)) begin
                        quotient_d  = MIN_VAL;
                        remainder_d = '0;
                        state_d     = S_DONE;
                    end else begin
                        rem_d     = '0;
                        quo_d     = dividend_abs;
                        div_d     = divisor_abs;
                        cnt_d     = '0;
                        neg_quo_d = dividend_neg ^ divisor_neg;
                        neg_rem_d = dividend_neg;
                        state_d   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = neg_quo_q ? (-step_quo) : step_quo;
                    remainder_d = neg_rem_q ? (-step_rem) : step_rem;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

endmodule
